// File: rtl/serial_bus_slave_mem.sv
// Bit-serial bus slave with burst access to a local word memory.
// Optional build macro SERIAL_SLAVE_PARITY_EN adds an even-parity bit after each data word.
module serial_bus_slave_mem #(
    parameter int unsigned ADDR_WIDTH     = 12,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned BURST_WIDTH    = 4,
    parameter int unsigned MEM_ADDR_WIDTH = 6
) (
    input  logic clk,
    input  logic reset,
    input  logic read_en,
    input  logic write_en,
    input  logic master_valid,
    input  logic master_ready,
    output logic slave_valid,
    output logic slave_ready,
    input  logic rx_address,
    input  logic rx_burst,
    input  logic rx_data,
    output logic tx_data,
    output logic rx_done,
    output logic slave_tx_done,
    output logic bus_error
);
    localparam int unsigned MEM_DEPTH = 2 ** MEM_ADDR_WIDTH;
`ifdef SERIAL_SLAVE_PARITY_EN
    localparam int unsigned PAR_BITS = 1;
`else
    localparam int unsigned PAR_BITS = 0;
`endif
    localparam int unsigned SH_W    = DATA_WIDTH + PAR_BITS;
    localparam int unsigned CNT_MAX = (ADDR_WIDTH > SH_W) ? ADDR_WIDTH : SH_W;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] ADDR_LAST  = CNT_W'(ADDR_WIDTH - 1);
    localparam logic [CNT_W-1:0] WORD_LAST  = CNT_W'(SH_W - 1);
    localparam logic [CNT_W-1:0] IDX_BITS   = CNT_W'(MEM_ADDR_WIDTH);
    localparam logic [CNT_W-1:0] BURST_BITS = CNT_W'(BURST_WIDTH);

    typedef enum logic [2:0] {IDLE, ADDR, WDATA, RLOAD, RDATA} state_e;

    state_e                    state_q, state_d;
    logic                      mode_wr_q, mode_wr_d;
    logic [CNT_W-1:0]          bit_cnt_q, bit_cnt_d;
    logic [MEM_ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [BURST_WIDTH-1:0]    burst_q, burst_d;
    logic [BURST_WIDTH-1:0]    word_cnt_q, word_cnt_d;
    logic [SH_W-1:0]           data_sh_q, data_sh_d;
    logic                      slave_valid_q, slave_valid_d;
    logic                      slave_ready_q, slave_ready_d;
    logic                      tx_data_q, tx_data_d;
    logic                      rx_done_q, rx_done_d;
    logic                      slave_tx_done_q, slave_tx_done_d;
    logic                      bus_error_q, bus_error_d;

    logic [DATA_WIDTH-1:0]     mem [MEM_DEPTH];
    logic [SH_W-1:0]           data_in_c;
    logic [DATA_WIDTH-1:0]     rd_word_c;
    logic [SH_W-1:0]           rd_frame_c;
    logic                      word_ok_c;
    logic                      wr_en_c;

    // Incoming bits enter at the MSB so the first (LSB) bit ends up at index 0.
    assign data_in_c = {rx_data, data_sh_q[SH_W-1:1]};
    assign rd_word_c = mem[idx_q];
`ifdef SERIAL_SLAVE_PARITY_EN
    assign word_ok_c  = ~^data_in_c;
    assign rd_frame_c = {^rd_word_c, rd_word_c};
`else
    assign word_ok_c  = 1'b1;
    assign rd_frame_c = rd_word_c;
`endif

    always_comb begin
        state_d         = state_q;
        mode_wr_d       = mode_wr_q;
        bit_cnt_d       = bit_cnt_q;
        idx_d           = idx_q;
        burst_d         = burst_q;
        word_cnt_d      = word_cnt_q;
        data_sh_d       = data_sh_q;
        tx_data_d       = 1'b0;
        rx_done_d       = 1'b0;
        slave_tx_done_d = 1'b0;
        bus_error_d     = 1'b0;
        wr_en_c         = 1'b0;

        case (state_q)
            IDLE: begin
                if (master_valid) begin
                    if (read_en && write_en) begin
                        bus_error_d = 1'b1;
                    end else if (read_en || write_en) begin
                        mode_wr_d  = write_en;
                        idx_d      = {rx_address, idx_q[MEM_ADDR_WIDTH-1:1]};
                        burst_d    = {rx_burst, burst_q[BURST_WIDTH-1:1]};
                        bit_cnt_d  = CNT_W'(1);
                        word_cnt_d = '0;
                        state_d    = ADDR;
                    end
                end
            end
            ADDR: begin
                if (master_valid) begin
                    // Only the low index bits and burst bits are kept; the rest shift past.
                    if (bit_cnt_q < IDX_BITS) begin
                        idx_d = {rx_address, idx_q[MEM_ADDR_WIDTH-1:1]};
                    end
                    if (bit_cnt_q < BURST_BITS) begin
                        burst_d = {rx_burst, burst_q[BURST_WIDTH-1:1]};
                    end
                    if (bit_cnt_q == ADDR_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = mode_wr_q ? WDATA : RLOAD;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            WDATA: begin
                if (master_valid) begin
                    data_sh_d = data_in_c;
                    if (bit_cnt_q == WORD_LAST) begin
                        bit_cnt_d   = '0;
                        wr_en_c     = reset && word_ok_c;
                        rx_done_d   = word_ok_c;
                        bus_error_d = ~word_ok_c;
                        if (word_cnt_q == burst_q) begin
                            state_d = IDLE;
                        end else begin
                            word_cnt_d = word_cnt_q + BURST_WIDTH'(1);
                            idx_d      = idx_q + MEM_ADDR_WIDTH'(1);
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            RLOAD: begin
                data_sh_d = rd_frame_c;
                tx_data_d = rd_frame_c[0];
                bit_cnt_d = '0;
                state_d   = RDATA;
            end
            RDATA: begin
                tx_data_d = tx_data_q;
                if (master_ready) begin
                    if (bit_cnt_q == WORD_LAST) begin
                        bit_cnt_d = '0;
                        tx_data_d = 1'b0;
                        if (word_cnt_q == burst_q) begin
                            state_d         = IDLE;
                            slave_tx_done_d = 1'b1;
                        end else begin
                            state_d    = RLOAD;
                            word_cnt_d = word_cnt_q + BURST_WIDTH'(1);
                            idx_d      = idx_q + MEM_ADDR_WIDTH'(1);
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        data_sh_d = {data_sh_q[0], data_sh_q[SH_W-1:1]};
                        tx_data_d = data_sh_q[1];
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Handshake flags follow the state being entered so they line up with it.
        slave_ready_d = (state_d != RLOAD) && (state_d != RDATA);
        slave_valid_d = (state_d == RDATA);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q         <= IDLE;
            mode_wr_q       <= 1'b0;
            bit_cnt_q       <= '0;
            idx_q           <= '0;
            burst_q         <= '0;
            word_cnt_q      <= '0;
            data_sh_q       <= '0;
            slave_valid_q   <= 1'b0;
            slave_ready_q   <= 1'b0;
            tx_data_q       <= 1'b0;
            rx_done_q       <= 1'b0;
            slave_tx_done_q <= 1'b0;
            bus_error_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            mode_wr_q       <= mode_wr_d;
            bit_cnt_q       <= bit_cnt_d;
            idx_q           <= idx_d;
            burst_q         <= burst_d;
            word_cnt_q      <= word_cnt_d;
            data_sh_q       <= data_sh_d;
            slave_valid_q   <= slave_valid_d;
            slave_ready_q   <= slave_ready_d;
            tx_data_q       <= tx_data_d;
            rx_done_q       <= rx_done_d;
            slave_tx_done_q <= slave_tx_done_d;
            bus_error_q     <= bus_error_d;
        end
    end

    // Word storage keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[idx_q] <= data_in_c[DATA_WIDTH-1:0];
        end
    end

    assign slave_valid   = slave_valid_q;
    assign slave_ready   = slave_ready_q;
    assign tx_data       = tx_data_q;
    assign rx_done       = rx_done_q;
    assign slave_tx_done = slave_tx_done_q;
    assign bus_error     = bus_error_q;

endmodule

// File: tb/tb_serial_bus_slave_mem.sv
// Randomized self-checking bench for serial_bus_slave_mem against an array memory model.
`timescale 1ns/1ps
module tb_serial_bus_slave_mem;
    localparam int unsigned AW    = 12;
    localparam int unsigned DW    = 8;
    localparam int unsigned BW    = 4;
    localparam int unsigned MAW   = 6;
    localparam int unsigned DEPTH = 64;
`ifdef SERIAL_SLAVE_PARITY_EN
    localparam int unsigned WB = DW + 1;
`else
    localparam int unsigned WB = DW;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic read_en = 1'b0, write_en = 1'b0;
    logic master_valid = 1'b0, master_ready = 1'b0;
    logic rx_address = 1'b0, rx_burst = 1'b0, rx_data = 1'b0;
    logic slave_valid, slave_ready, tx_data, rx_done, slave_tx_done, bus_error;

    logic [DW-1:0] model_mem [DEPTH];
    logic [DW-1:0] wq [$];
    int n_checks = 0;
    int n_pass   = 0;
    int stall_mode = 0;

    serial_bus_slave_mem dut (
        .clk(clk), .reset(reset), .read_en(read_en), .write_en(write_en),
        .master_valid(master_valid), .master_ready(master_ready),
        .slave_valid(slave_valid), .slave_ready(slave_ready),
        .rx_address(rx_address), .rx_burst(rx_burst), .rx_data(rx_data),
        .tx_data(tx_data), .rx_done(rx_done), .slave_tx_done(slave_tx_done),
        .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // mode 1: idle cycle before every bit; mode 2: random idle cycles
    function automatic bit do_stall();
        if (stall_mode == 1) return 1'b1;
        if (stall_mode == 2) return ($urandom_range(0, 3) == 0);
        return 1'b0;
    endfunction

    task automatic send_header(input bit wr, input logic [AW-1:0] addr, input logic [BW-1:0] burst);
        logic exp_rdy;
        for (int i = 0; i < int'(AW); i++) begin
            if (do_stall()) begin
                master_valid = 1'b0;
                read_en = 1'($urandom); write_en = 1'($urandom);
                rx_address = 1'($urandom); rx_burst = 1'($urandom);
                step();
                n_checks++;
                if (slave_ready !== 1'b1) $display("FAIL hdr_stall_ready bit %0d: got %b want 1", i, slave_ready);
                else n_pass++;
            end
            master_valid = 1'b1;
            rx_address = addr[i];
            rx_burst = (i < int'(BW)) ? burst[i] : 1'($urandom);
            if (i == 0) begin
                write_en = wr; read_en = ~wr;
            end else begin
                write_en = 1'($urandom); read_en = 1'($urandom);
            end
            step();
            exp_rdy = (i == int'(AW) - 1) ? wr : 1'b1;
            n_checks++;
            if (slave_ready !== exp_rdy) $display("FAIL hdr_ready bit %0d: got %b want %b", i, slave_ready, exp_rdy);
            else n_pass++;
        end
        master_valid = 1'b0; read_en = 1'b0; write_en = 1'b0;
    endtask

    task automatic write_burst(input logic [AW-1:0] addr, input int unsigned bad_mask);
        logic [MAW-1:0] idx;
        logic [WB-1:0] frame;
        logic bad;
        idx = addr[MAW-1:0];
        send_header(1'b1, addr, BW'(wq.size() - 1));
        foreach (wq[w]) begin
            bad = bad_mask[w];
            frame = WB'({^wq[w] ^ bad, wq[w]});
            for (int b = 0; b < int'(WB); b++) begin
                if (do_stall()) begin
                    master_valid = 1'b0; rx_data = 1'($urandom);
                    step();
                    n_checks++;
                    if (rx_done !== 1'b0 || bus_error !== 1'b0)
                        $display("FAIL wr_stall_pulse: rx_done=%b bus_error=%b want 0 0", rx_done, bus_error);
                    else n_pass++;
                end
                master_valid = 1'b1; rx_data = frame[b];
                step();
                n_checks++;
                if (b == int'(WB) - 1) begin
                    if (rx_done !== ~bad || bus_error !== bad)
                        $display("FAIL wr_done word %0d: rx_done=%b bus_error=%b want %b %b", w, rx_done, bus_error, ~bad, bad);
                    else n_pass++;
                end else begin
                    if (rx_done !== 1'b0) $display("FAIL wr_early_done word %0d bit %0d: got %b want 0", w, b, rx_done);
                    else n_pass++;
                end
            end
            if (!bad) model_mem[idx] = wq[w];
            idx = MAW'(idx + 1);
        end
        master_valid = 1'b0;
        n_checks++;
        if (slave_ready !== 1'b1 || slave_valid !== 1'b0)
            $display("FAIL wr_end_idle: ready=%b valid=%b want 1 0", slave_ready, slave_valid);
        else n_pass++;
    endtask

    task automatic read_burst(input logic [AW-1:0] addr, input int nwords);
        logic [MAW-1:0] idx;
        logic [WB-1:0] frame;
        logic [DW-1:0] exp_w;
        idx = addr[MAW-1:0];
        send_header(1'b0, addr, BW'(nwords - 1));
        n_checks++;
        if (slave_valid !== 1'b0) $display("FAIL rd_load_valid: got %b want 0", slave_valid);
        else n_pass++;
        for (int w = 0; w < nwords; w++) begin
            exp_w = model_mem[idx];
            frame = WB'({^exp_w, exp_w});
            master_ready = 1'($urandom);
            step();
            for (int b = 0; b < int'(WB); b++) begin
                if (do_stall()) begin
                    master_ready = 1'b0;
                    step();
                end
                n_checks++;
                if (slave_valid !== 1'b1 || tx_data !== frame[b] || slave_ready !== 1'b0)
                    $display("FAIL rd_bit idx %0d bit %0d: valid=%b tx=%b ready=%b want 1 %b 0",
                             idx, b, slave_valid, tx_data, slave_ready, frame[b]);
                else n_pass++;
                master_ready = 1'b1;
                step();
            end
            master_ready = 1'b0;
            n_checks++;
            if (w < nwords - 1) begin
                if (slave_valid !== 1'b0 || slave_tx_done !== 1'b0)
                    $display("FAIL rd_bubble word %0d: valid=%b tx_done=%b want 0 0", w, slave_valid, slave_tx_done);
                else n_pass++;
            end else begin
                if (slave_tx_done !== 1'b1 || slave_valid !== 1'b0 || slave_ready !== 1'b1 || tx_data !== 1'b0)
                    $display("FAIL rd_end: tx_done=%b valid=%b ready=%b tx=%b want 1 0 1 0",
                             slave_tx_done, slave_valid, slave_ready, tx_data);
                else n_pass++;
            end
            idx = MAW'(idx + 1);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step(); step();
        n_checks++;
        if ({slave_valid, slave_ready, tx_data, rx_done, slave_tx_done, bus_error} !== 6'b0)
            $display("FAIL reset_outputs: got %b want 000000",
                     {slave_valid, slave_ready, tx_data, rx_done, slave_tx_done, bus_error});
        else n_pass++;
        reset = 1'b1;
        step();
        n_checks++;
        if (slave_ready !== 1'b1 || slave_valid !== 1'b0)
            $display("FAIL reset_release: ready=%b valid=%b want 1 0", slave_ready, slave_valid);
        else n_pass++;
    endtask

    task automatic test_single();
        wq.delete(); wq.push_back(8'hBD);
        write_burst(12'hADD, 0);
        read_burst(12'h01D, 1);
        step();
        n_checks++;
        if (slave_tx_done !== 1'b0) $display("FAIL tx_done_one_cycle: got %b want 0", slave_tx_done);
        else n_pass++;
    endtask

    task automatic test_burst_wrap();
        wq.delete();
        wq.push_back(8'h11); wq.push_back(8'h22); wq.push_back(8'h33); wq.push_back(8'h44);
        write_burst(12'h7FE, 0);
        read_burst(12'h03E, 4);
        read_burst(12'hC00, 2);
    endtask

    task automatic test_stall_alternate();
        stall_mode = 1;
        wq.delete();
        for (int i = 0; i < 3; i++) wq.push_back(DW'($urandom));
        write_burst(12'h114, 0);
        read_burst(12'h014, 3);
        stall_mode = 0;
    endtask

    task automatic test_dual_enable();
        master_valid = 1'b1; read_en = 1'b1; write_en = 1'b1; rx_address = 1'b1; rx_burst = 1'b1;
        step();
        n_checks++;
        if (bus_error !== 1'b1 || slave_ready !== 1'b1)
            $display("FAIL dual_enable: bus_error=%b ready=%b want 1 1", bus_error, slave_ready);
        else n_pass++;
        master_valid = 1'b0; read_en = 1'b0; write_en = 1'b0;
        step();
        n_checks++;
        if (bus_error !== 1'b0) $display("FAIL dual_enable_pulse: got %b want 0", bus_error);
        else n_pass++;
        wq.delete(); wq.push_back(8'h6C);
        write_burst(12'h00A, 0);
        read_burst(12'hF0A, 1);
    endtask

    task automatic test_reset_mid_burst();
        logic [WB-1:0] frame;
        wq.delete(); wq.push_back(8'hA5);
        write_burst(12'h006, 0);
        send_header(1'b1, 12'h405, 4'd1);
        frame = WB'({^8'h5A, 8'h5A});
        for (int b = 0; b < int'(WB); b++) begin
            master_valid = 1'b1; rx_data = frame[b];
            step();
        end
        n_checks++;
        if (rx_done !== 1'b1) $display("FAIL mid_word1_done: got %b want 1", rx_done);
        else n_pass++;
        model_mem[5] = 8'h5A;
        frame = WB'({^8'hC3, 8'hC3});
        for (int b = 0; b < 4; b++) begin
            master_valid = 1'b1; rx_data = frame[b];
            step();
        end
        master_valid = 1'b0; reset = 1'b0;
        step();
        n_checks++;
        if (slave_ready !== 1'b0 || rx_done !== 1'b0)
            $display("FAIL mid_reset_outputs: ready=%b rx_done=%b want 0 0", slave_ready, rx_done);
        else n_pass++;
        reset = 1'b1;
        step();
        n_checks++;
        if (slave_ready !== 1'b1) $display("FAIL mid_reset_release: got %b want 1", slave_ready);
        else n_pass++;
        read_burst(12'h005, 2);
    endtask

    task automatic test_back_to_back();
        wq.delete(); wq.push_back(8'h96); wq.push_back(8'h3F);
        write_burst(12'h032, 0);
        read_burst(12'h032, 2);
        read_burst(12'h033, 1);
        wq.delete(); wq.push_back(8'hE1);
        write_burst(12'h832, 0);
        read_burst(12'h032, 1);
    endtask

    task automatic test_random();
        logic [MAW-1:0] base;
        int n;
        stall_mode = 2;
        for (int t = 0; t < 8; t++) begin
            base = MAW'($urandom);
            n = $urandom_range(1, 4);
            wq.delete();
            for (int i = 0; i < n; i++) wq.push_back(DW'($urandom));
            write_burst({6'($urandom), base}, 0);
            read_burst({6'($urandom), base}, n);
        end
        stall_mode = 0;
    endtask

`ifdef SERIAL_SLAVE_PARITY_EN
    task automatic test_parity();
        wq.delete(); wq.push_back(8'h00);
        write_burst(12'h028, 0);
        wq.delete(); wq.push_back(8'hBD);
        write_burst(12'h028, 1);
        read_burst(12'h028, 1);
        write_burst(12'h028, 0);
        read_burst(12'h028, 1);
        wq.delete(); wq.push_back(8'h00); wq.push_back(8'h00);
        write_burst(12'h029, 0);
        wq.delete(); wq.push_back(8'hFF); wq.push_back(8'h77);
        write_burst(12'h029, 1);
        read_burst(12'h029, 2);
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_burst_wrap();
        test_stall_alternate();
        test_dual_enable();
        test_reset_mid_burst();
        test_back_to_back();
        test_random();
`ifdef SERIAL_SLAVE_PARITY_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/serial_bus_slave_mem.md
# serial_bus_slave_mem

Parametrised serial bus slave with an internal word memory and burst support, the next-generation slave endpoint of the system bus. It receives a bit-serial address, burst length and write data from a master, stores words in a local memory with auto-incrementing address, and returns bit-serial read data under a valid/ready handshake. It sits behind the bus arbiter/mux as one addressable slave port.

## Interface
- ADDR_WIDTH, 12, serial address field length in bits
- DATA_WIDTH, 8, word width in bits
- BURST_WIDTH, 4, burst-length field width; must be ≤ ADDR_WIDTH
- MEM_ADDR_WIDTH, 6, internal memory index width; MEM_DEPTH = 2**MEM_ADDR_WIDTH
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-low reset
- read_en  input  1  request read transaction (sampled in IDLE)
- write_en  input  1  request write transaction (sampled in IDLE)
- master_valid  input  1  master drives valid rx_address/rx_burst/rx_data bit this cycle
- master_ready  input  1  master accepts current tx_data bit this cycle
- slave_valid  output  1  tx_data holds a valid read bit
- slave_ready  output  1  slave accepts rx bits this cycle
- rx_address  input  1  serial address, LSB first
- rx_burst  input  1  serial burst length, LSB first
- rx_data  input  1  serial write data, LSB first
- tx_data  output  1  serial read data, LSB first
- rx_done  output  1  one-cycle pulse per word written
- slave_tx_done  output  1  one-cycle pulse at end of read burst
- bus_error  output  1  one-cycle pulse on protocol/parity error

## Operation
- States: IDLE, ADDR, WDATA, RLOAD, RDATA.
- IDLE: slave_ready=1. On master_valid=1 with exactly one of write_en/read_en high: bit on rx_address is address bit 0, bit on rx_burst is burst bit 0; latch mode; go ADDR. Both enables high with master_valid=1: bus_error pulse, stay IDLE. Neither: stay IDLE.
- ADDR: slave_ready=1; one bit per master_valid=1 cycle; master_valid=0 stalls. rx_burst sampled only for first BURST_WIDTH bits. After bit ADDR_WIDTH-1: write → WDATA, read → RLOAD.
- Memory index = address[MEM_ADDR_WIDTH-1:0]; upper address bits ignored. Burst field N transfers N+1 words. Index increments per word, wraps MEM_DEPTH-1 → 0.
- WDATA: slave_ready=1; shift rx_data on master_valid cycles; after DATA_WIDTH bits word is written at current index on that edge; rx_done pulses the following cycle. After N+1 words → IDLE; else next word.
- RLOAD: slave_ready=0, slave_valid=0; one cycle reading memory into shift register → RDATA.
- RDATA: slave_valid=1, tx_data = current bit. Advance on master_ready=1; hold otherwise. After last bit of a word: more words → RLOAD; last word → IDLE with slave_tx_done pulse in the first IDLE cycle.
- Memory contents are not cleared by reset.

## Timing
- Reset (reset=0 at edge): state IDLE, all counters 0; slave_valid=0, slave_ready=0 during reset, 1 from first cycle after reset released; tx_data=0, rx_done=0, slave_tx_done=0, bus_error=0.
- Reset mid-transaction: abort, partially shifted word is discarded, no memory write.
- Write latency: rx_done high one cycle after the edge sampling the last data bit.
- Read latency: first tx_data bit valid two cycles after the edge sampling last address bit (one RLOAD cycle); one RLOAD bubble between burst words.
- read_en/write_en ignored outside IDLE.
- Read-after-write to the same index in a later transaction returns the new value.

## Configuration
- SERIAL_SLAVE_PARITY_EN defined: each data word carries one extra even-parity bit after the MSB, both directions. Write: mismatch → word not written, bus_error pulse in place of rx_done, burst continues. Read: slave appends even parity bit of the word.
- Undefined: exactly DATA_WIDTH bits per word, bus_error only for dual-enable.

## Test plan
- Write 8'hBD to address 12'hADD, burst 0 → rx_done one pulse; memory[29] = 8'hBD; back to IDLE.
- Read address 12'h01D, burst 0, master_ready=1 → tx_data 1,0,1,1,1,1,0,1; slave_tx_done pulse after 8th bit.
- Write burst 3 at index 62 with 8'h11,22,33,44 → indices 62,63,0,1 written; read back burst 3 returns same order.
- master_valid/master_ready toggled every other cycle during write and read → identical data, transfer time doubled, no lost bits.
- read_en=write_en=1 with master_valid=1 → bus_error pulse, state stays IDLE; reset=0 mid write burst word 2 → word 2 unwritten, word 1 retained.
- With SERIAL_SLAVE_PARITY_EN, write 8'hBD with parity 1 → bus_error, no write; parity 0 → written; read appends 0.
